pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush sequencer for the five-stage pipeline.
- Drives the write-enable and nop-insert (flush) controls of the PC, fetch/decode, decode/execute, execute/memory and memory/writeback latches.
- Resolves load-use hazards, taken branches/jumps, instruction- and data-memory busy stalls, and halt draining into one prioritised decision per cycle.
- Keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- REG_ADDR_W, 3, register-specifier width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rs1_d, rs2_d  in  REG_ADDR_W  source registers of the instruction in decode
- useRs1_d, useRs2_d  in  1  decode instruction actually reads rs1/rs2
- halt_d  in  1  decode instruction is HALT
- memRead_x  in  1  execute instruction is a load
- writeReg_x  in  REG_ADDR_W  destination register of the execute instruction
- redirect_x  in  1  taken branch or jump resolved in execute
- halt_wb  in  1  HALT has reached writeback
- imemStall  in  1  instruction memory busy this cycle
- dmemStall  in  1  data memory busy this cycle
- pcWriteEn, fdWriteEn, dxWriteEn, xmWriteEn, mwWriteEn  out  1  latch write enables
- fdFlush, dxFlush  out  1  load a nop into the latch instead of its input (only meaningful with the matching writeEn=1)
- haltDone  out  1  pipeline fully drained after HALT
- stallCount  out  CNT_W  stall cycles since reset

## Operation
- FSM states:
  - RUN: normal operation.
  - DRAIN: a HALT is decoded; the pipeline is being emptied.
  - HALTED: terminal state.
- loadUse = memRead_x & ((useRs1_d & rs1_d==writeReg_x) | (useRs2_d & rs2_d==writeReg_x)).
- RUN, first match wins; every write enable not listed is 1 and every flush not listed is 0:
  1. dmemStall: all five writeEn=0.
  2. redirect_x: pcWriteEn=1, fdFlush=1, dxFlush=1. Any halt_d or loadUse is ignored because the decode instruction is squashed.
  3. loadUse: pcWriteEn=0, fdWriteEn=0, dxFlush=1.
  4. imemStall: pcWriteEn=0, fdFlush=1.
  5. halt_d: pcWriteEn=0, fdFlush=1; next state DRAIN. The HALT itself advances into decode/execute.
- DRAIN:
  - pcWriteEn=0 and fdFlush=1 always.
  - dmemStall freezes all latches.
  - redirect_x (an older taken branch, so the HALT was wrong-path) applies rule 2 with pcWriteEn=1 and next state RUN.
  - halt_wb goes to HALTED.
  - loadUse and imemStall are ignored: decode holds only nops.
- HALTED: all writeEn=0, flushes=0, haltDone=1. Only rst leaves this state.
- stallCount increments by 1 in any RUN/DRAIN cycle where rule 1, 3 or 4 applies (DRAIN: dmemStall only). It saturates at all-ones and never wraps.
- A register compare uses the full address. Register 0 is an ordinary register and is not special-cased.

## Timing
- All outputs are combinational from the current inputs plus the registered state; they are valid in the same cycle.
- State and stallCount update on the rising edge of clk.
- Reset, asynchronous, effective immediately:
  - state=RUN, stallCount=0, haltDone=0.
  - While rst is high: all writeEn=0, all flushes=0.
- Latencies:
  - A HALT decoded in cycle N makes DRAIN visible in N+1.
  - haltDone asserts in the cycle after halt_wb is sampled high.
  - A load-use hazard costs exactly one bubble: the next cycle has memRead_x=0 for that slot.
- Simultaneous events:
  - dmemStall with redirect_x: freeze only. The redirect is re-presented next cycle because execute holds.
  - halt_wb with dmemStall in DRAIN: go to HALTED; writeback has already committed.
  - rst asserted mid-DRAIN: returns to RUN immediately.

## Structure
- Shared package pipeline_ctrl_pkg:
  - 2-bit state encodings S_RUN=0, S_DRAIN=1, S_HALTED=2. The encoding 3 is illegal and recovers to RUN.
  - REG_ADDR_W and CNT_W defaults.
- One sub-module, load_use_detect (combinational comparator producing loadUse).
- The FSM, priority mux and counter live in the top module.

## Test plan
- Load then dependent ALU: memRead_x=1, writeReg_x=3, rs1_d=3, useRs1_d=1 -> pcWriteEn=0, fdWriteEn=0, dxFlush=1 for one cycle; stallCount 0->1.
- Same stimulus with useRs1_d=0 -> no stall; all writeEn=1.
- redirect_x=1 together with loadUse=1 and halt_d=1 -> fdFlush=dxFlush=1, pcWriteEn=1; state stays RUN; stallCount unchanged.
- dmemStall held 5 cycles with redirect_x=1 -> all writeEn=0 for 5 cycles, stallCount +5; flush fires on the 6th cycle.
- HALT path: halt_d=1 -> DRAIN next cycle; pcWriteEn=0; halt_wb=1 three cycles later -> haltDone=1 the following cycle, all writeEn=0 until rst. Variant: redirect_x in DRAIN -> back to RUN.
- Counter saturation: preload the bench with CNT_W=4, stall 20 cycles -> stallCount sticks at 15. Asynchronous rst mid-stall -> stallCount=0 and writeEn=0 without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// State encodings, latch-control bundle and default widths.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 3;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DRAIN   = 2'd1,
        S_HALTED  = 2'd2,
        S_ILLEGAL = 2'd3
    } state_e;

    typedef struct packed {
        logic pc;
        logic fd;
        logic dx;
        logic xm;
        logic mw;
        logic fd_flush;
        logic dx_flush;
    } ctl_t;

    localparam ctl_t CTL_PASS = '{pc: 1'b1, fd: 1'b1, dx: 1'b1, xm: 1'b1, mw: 1'b1,
                                  fd_flush: 1'b0, dx_flush: 1'b0};
    localparam ctl_t CTL_FREEZE = '{default: 1'b0};

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and latch controls between the pipeline datapath and the stall sequencer.
// master = datapath side, slave = sequencer.
interface pipeline_stall_ctrl_if #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic                  useRs1_d;
    logic                  useRs2_d;
    logic                  halt_d;
    logic                  memRead_x;
    logic [REG_ADDR_W-1:0] writeReg_x;
    logic                  redirect_x;
    logic                  halt_wb;
    logic                  imemStall;
    logic                  dmemStall;

    logic                  pcWriteEn;
    logic                  fdWriteEn;
    logic                  dxWriteEn;
    logic                  xmWriteEn;
    logic                  mwWriteEn;
    logic                  fdFlush;
    logic                  dxFlush;
    logic                  haltDone;
    logic [CNT_W-1:0]      stallCount;

    modport master (
        output rs1_d, rs2_d, useRs1_d, useRs2_d, halt_d, memRead_x, writeReg_x,
               redirect_x, halt_wb, imemStall, dmemStall,
        input  pcWriteEn, fdWriteEn, dxWriteEn, xmWriteEn, mwWriteEn,
               fdFlush, dxFlush, haltDone, stallCount
    );

    modport slave (
        input  rs1_d, rs2_d, useRs1_d, useRs2_d, halt_d, memRead_x, writeReg_x,
               redirect_x, halt_wb, imemStall, dmemStall,
        output pcWriteEn, fdWriteEn, dxWriteEn, xmWriteEn, mwWriteEn,
               fdFlush, dxFlush, haltDone, stallCount
    );
endinterface

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Load-use hazard comparator: decode reads a register the load in execute is writing.
// Register 0 is compared like any other register.
module load_use_detect #(
    parameter int REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] i_rs1_d,
    input  logic [REG_ADDR_W-1:0] i_rs2_d,
    input  logic                  i_use_rs1_d,
    input  logic                  i_use_rs2_d,
    input  logic                  i_mem_read_x,
    input  logic [REG_ADDR_W-1:0] i_write_reg_x,
    output logic                  o_load_use
);
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1  = i_use_rs1_d && (i_rs1_d == i_write_reg_x);
    assign w_hit_rs2  = i_use_rs2_d && (i_rs2_d == i_write_reg_x);
    assign o_load_use = i_mem_read_x && (w_hit_rs1 || w_hit_rs2);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: prioritised latch control, halt draining FSM
// and a saturating stall-cycle counter.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_stall_ctrl_if.slave  bus
);
    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_load_use;
    logic             w_stall_inc;
    logic             w_halt_done;
    ctl_t             w_ctl;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
        .i_rs1_d       (bus.rs1_d),
        .i_rs2_d       (bus.rs2_d),
        .i_use_rs1_d   (bus.useRs1_d),
        .i_use_rs2_d   (bus.useRs2_d),
        .i_mem_read_x  (bus.memRead_x),
        .i_write_reg_x (bus.writeReg_x),
        .o_load_use    (w_load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        w_ctl        = CTL_FREEZE;
        w_stall_inc  = 1'b0;
        w_halt_done  = 1'b0;
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                w_ctl = CTL_PASS;
                if (bus.dmemStall) begin
                    w_ctl       = CTL_FREEZE;
                    w_stall_inc = 1'b1;
                end else if (bus.redirect_x) begin
                    w_ctl.fd_flush = 1'b1;
                    w_ctl.dx_flush = 1'b1;
                end else if (w_load_use) begin
                    w_ctl.pc       = 1'b0;
                    w_ctl.fd       = 1'b0;
                    w_ctl.dx_flush = 1'b1;
                    w_stall_inc    = 1'b1;
                end else if (bus.imemStall) begin
                    w_ctl.pc       = 1'b0;
                    w_ctl.fd_flush = 1'b1;
                    w_stall_inc    = 1'b1;
                end else if (bus.halt_d) begin
                    w_ctl.pc       = 1'b0;
                    w_ctl.fd_flush = 1'b1;
                    w_next_state   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Decode holds only nops here, so load-use and imem stalls are irrelevant.
                w_ctl          = CTL_PASS;
                w_ctl.pc       = 1'b0;
                w_ctl.fd_flush = 1'b1;
                if (bus.dmemStall) begin
                    w_ctl       = CTL_FREEZE;
                    w_stall_inc = 1'b1;
                    if (bus.halt_wb)
                        w_next_state = S_HALTED;
                end else if (bus.redirect_x) begin
                    w_ctl.pc       = 1'b1;
                    w_ctl.dx_flush = 1'b1;
                    w_next_state   = S_RUN;
                end else if (bus.halt_wb) begin
                    w_next_state = S_HALTED;
                end
            end
            S_HALTED: begin
                w_halt_done = 1'b1;
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
        if (rst) begin
            w_ctl       = CTL_FREEZE;
            w_stall_inc = 1'b0;
            w_halt_done = 1'b0;
        end
    end

    assign bus.pcWriteEn  = w_ctl.pc;
    assign bus.fdWriteEn  = w_ctl.fd;
    assign bus.dxWriteEn  = w_ctl.dx;
    assign bus.xmWriteEn  = w_ctl.xm;
    assign bus.mwWriteEn  = w_ctl.mw;
    assign bus.fdFlush    = w_ctl.fd_flush;
    assign bus.dxFlush    = w_ctl.dx_flush;
    assign bus.haltDone   = w_halt_done;
    assign bus.stallCount = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus a
// randomized run against a behavioural model. Counter width 4 so saturation is reachable.
module tb_pipeline_stall_ctrl;
    localparam int RW = 3;
    localparam int CW = 4;

    // Control vector order: {pc, fd, dx, xm, mw, fdFlush, dxFlush}
    localparam logic [6:0] C_PASS   = 7'b1111100;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_REDIR  = 7'b1111111;
    localparam logic [6:0] C_LDUSE  = 7'b0011101;
    localparam logic [6:0] C_HOLDPC = 7'b0111110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    pipeline_stall_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [6:0] ctl();
        return {bus.pcWriteEn, bus.fdWriteEn, bus.dxWriteEn, bus.xmWriteEn,
                bus.mwWriteEn, bus.fdFlush, bus.dxFlush};
    endfunction

    task automatic clear_inputs();
        bus.rs1_d = '0; bus.rs2_d = '0; bus.useRs1_d = 1'b0; bus.useRs2_d = 1'b0;
        bus.halt_d = 1'b0; bus.memRead_x = 1'b0; bus.writeReg_x = '0;
        bus.redirect_x = 1'b0; bus.halt_wb = 1'b0; bus.imemStall = 1'b0; bus.dmemStall = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_tests++; if (ctl() !== C_FREEZE) begin n_fail++; $display("FAIL reset_ctl: got %b exp %b", ctl(), C_FREEZE); end
        n_tests++; if (bus.stallCount !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", bus.stallCount); end
        n_tests++; if (bus.haltDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", bus.haltDone); end
        rst = 1'b0;
        #1;
        n_tests++; if (ctl() !== C_PASS) begin n_fail++; $display("FAIL reset_release: got %b exp %b", ctl(), C_PASS); end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        bus.memRead_x = 1'b1; bus.writeReg_x = 3'd3; bus.rs1_d = 3'd3; bus.useRs1_d = 1'b1;
        #1;
        n_tests++; if (ctl() !== C_LDUSE) begin n_fail++; $display("FAIL load_use_rs1: got %b exp %b", ctl(), C_LDUSE); end
        @(negedge clk);
        bus.memRead_x = 1'b0;
        #1;
        n_tests++; if (ctl() !== C_PASS) begin n_fail++; $display("FAIL load_use_bubble: got %b exp %b", ctl(), C_PASS); end
        n_tests++; if (bus.stallCount !== 4'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d exp 1", bus.stallCount); end
        // Same stimulus but rs1 not read: no hazard
        @(negedge clk);
        bus.memRead_x = 1'b1; bus.useRs1_d = 1'b0;
        #1;
        n_tests++; if (ctl() !== C_PASS) begin n_fail++; $display("FAIL no_use: got %b exp %b", ctl(), C_PASS); end
        @(negedge clk);
        bus.rs1_d = 3'd1; bus.rs2_d = 3'd3; bus.useRs2_d = 1'b1;
        #1;
        n_tests++; if (ctl() !== C_LDUSE) begin n_fail++; $display("FAIL load_use_rs2: got %b exp %b", ctl(), C_LDUSE); end
        @(negedge clk);
        bus.useRs2_d = 1'b0; bus.writeReg_x = 3'd0; bus.rs1_d = 3'd0; bus.useRs1_d = 1'b1;
        #1;
        n_tests++; if (ctl() !== C_LDUSE) begin n_fail++; $display("FAIL load_use_r0: got %b exp %b", ctl(), C_LDUSE); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++; if (bus.stallCount !== 4'd3) begin n_fail++; $display("FAIL load_use_cnt3: got %0d exp 3", bus.stallCount); end
    endtask

    task automatic test_redirect_priority();
        do_reset();
        @(negedge clk);
        bus.redirect_x = 1'b1; bus.halt_d = 1'b1;
        bus.memRead_x = 1'b1; bus.writeReg_x = 3'd5; bus.rs1_d = 3'd5; bus.useRs1_d = 1'b1;
        #1;
        n_tests++; if (ctl() !== C_REDIR) begin n_fail++; $display("FAIL redirect_prio: got %b exp %b", ctl(), C_REDIR); end
        @(negedge clk);
        clear_inputs();
        #1;
        n_tests++; if (ctl() !== C_PASS) begin n_fail++; $display("FAIL redirect_stays_run: got %b exp %b", ctl(), C_PASS); end
        n_tests++; if (bus.stallCount !== 4'd0) begin n_fail++; $display("FAIL redirect_cnt: got %0d exp 0", bus.stallCount); end
    endtask

    task automatic test_dmem_redirect();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.dmemStall = 1'b1; bus.redirect_x = 1'b1;
            #1;
            n_tests++; if (ctl() !== C_FREEZE) begin n_fail++; $display("FAIL dmem_freeze[%0d]: got %b exp %b", i, ctl(), C_FREEZE); end
        end
        @(negedge clk);
        bus.dmemStall = 1'b0;
        #1;
        n_tests++; if (ctl() !== C_REDIR) begin n_fail++; $display("FAIL dmem_then_flush: got %b exp %b", ctl(), C_REDIR); end
        n_tests++; if (bus.stallCount !== 4'd5) begin n_fail++; $display("FAIL dmem_cnt: got %0d exp 5", bus.stallCount); end
    endtask

    task automatic test_halt();
        do_reset();
        @(negedge clk);
        bus.halt_d = 1'b1;
        #1;
        n_tests++; if (ctl() !== C_HOLDPC) begin n_fail++; $display("FAIL halt_decode: got %b exp %b", ctl(), C_HOLDPC); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_inputs();
            bus.imemStall = (i == 0);
            bus.memRead_x = (i == 1); bus.useRs1_d = 1'b1;
            bus.halt_wb = (i == 2);
            #1;
            n_tests++; if (ctl() !== C_HOLDPC) begin n_fail++; $display("FAIL drain[%0d]: got %b exp %b", i, ctl(), C_HOLDPC); end
            n_tests++; if (bus.haltDone !== 1'b0) begin n_fail++; $display("FAIL drain_done[%0d]: got %b exp 0", i, bus.haltDone); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_inputs();
            bus.dmemStall = (i == 1); bus.redirect_x = (i == 2);
            #1;
            n_tests++; if (ctl() !== C_FREEZE) begin n_fail++; $display("FAIL halted_ctl[%0d]: got %b exp %b", i, ctl(), C_FREEZE); end
            n_tests++; if (bus.haltDone !== 1'b1) begin n_fail++; $display("FAIL halted_done[%0d]: got %b exp 1", i, bus.haltDone); end
        end
        n_tests++; if (bus.stallCount !== 4'd0) begin n_fail++; $display("FAIL halt_cnt: got %0d exp 0", bus.stallCount); end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        n_tests++; if (bus.haltDone !== 1'b0) begin n_fail++; $display("FAIL halted_rst: got %b exp 0", bus.haltDone); end
        rst = 1'b0;
    endtask

    task automatic test_halt_variants();
        // Redirect while draining returns to RUN
        do_reset();
        @(negedge clk); bus.halt_d = 1'b1;
        @(negedge clk); bus.halt_d = 1'b0; bus.redirect_x = 1'b1;
        #1;
        n_tests++; if (ctl() !== C_REDIR) begin n_fail++; $display("FAIL drain_redirect: got %b exp %b", ctl(), C_REDIR); end
        @(negedge clk); bus.redirect_x = 1'b0;
        #1;
        n_tests++; if (ctl() !== C_PASS) begin n_fail++; $display("FAIL drain_back_run: got %b exp %b", ctl(), C_PASS); end
        // Reset mid-drain acts immediately
        @(negedge clk); bus.halt_d = 1'b1;
        @(negedge clk); bus.halt_d = 1'b0;
        #1;
        n_tests++; if (ctl() !== C_HOLDPC) begin n_fail++; $display("FAIL drain_pre_rst: got %b exp %b", ctl(), C_HOLDPC); end
        rst = 1'b1;
        #1;
        n_tests++; if (ctl() !== C_FREEZE) begin n_fail++; $display("FAIL drain_rst_ctl: got %b exp %b", ctl(), C_FREEZE); end
        rst = 1'b0;
        #1;
        n_tests++; if (ctl() !== C_PASS) begin n_fail++; $display("FAIL drain_rst_run: got %b exp %b", ctl(), C_PASS); end
        // halt_wb together with dmemStall still halts; the stall is counted
        @(negedge clk); bus.halt_d = 1'b1;
        @(negedge clk); bus.halt_d = 1'b0; bus.dmemStall = 1'b1; bus.halt_wb = 1'b1;
        #1;
        n_tests++; if (ctl() !== C_FREEZE) begin n_fail++; $display("FAIL drain_dmem_wb: got %b exp %b", ctl(), C_FREEZE); end
        @(negedge clk); clear_inputs();
        #1;
        n_tests++; if (bus.haltDone !== 1'b1) begin n_fail++; $display("FAIL drain_dmem_done: got %b exp 1", bus.haltDone); end
        n_tests++; if (bus.stallCount !== 4'd1) begin n_fail++; $display("FAIL drain_dmem_cnt: got %0d exp 1", bus.stallCount); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.imemStall = 1'b1;
            #1;
            n_tests++; if (bus.stallCount !== 4'((i > 15) ? 15 : i)) begin
                n_fail++; $display("FAIL sat_cnt[%0d]: got %0d exp %0d", i, bus.stallCount, (i > 15) ? 15 : i);
            end
        end
        @(negedge clk);
        #1;
        n_tests++; if (bus.stallCount !== 4'd15) begin n_fail++; $display("FAIL sat_final: got %0d exp 15", bus.stallCount); end
        n_tests++; if (ctl() !== C_HOLDPC) begin n_fail++; $display("FAIL sat_ctl: got %b exp %b", ctl(), C_HOLDPC); end
        rst = 1'b1;
        #1;
        n_tests++; if (bus.stallCount !== 4'd0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d exp 0", bus.stallCount); end
        n_tests++; if (ctl() !== C_FREEZE) begin n_fail++; $display("FAIL async_rst_ctl: got %b exp %b", ctl(), C_FREEZE); end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_random();
        int         mode;      // 0 running, 1 draining, 2 halted
        int         cnt;
        int         halted_cycles;
        logic [6:0] exp_ctl;
        logic       inc;
        logic       lu;
        int         next_mode;
        do_reset();
        mode = 0; cnt = 0; halted_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i % 50 == 49 || halted_cycles > 3) begin
                rst = 1'b1; #1; rst = 1'b0;
                mode = 0; cnt = 0; halted_cycles = 0;
            end
            bus.rs1_d      = 3'($urandom_range(0, 7));
            bus.rs2_d      = 3'($urandom_range(0, 7));
            bus.writeReg_x = 3'($urandom_range(0, 7));
            bus.useRs1_d   = 1'($urandom_range(0, 1));
            bus.useRs2_d   = 1'($urandom_range(0, 1));
            bus.memRead_x  = ($urandom_range(0, 2) == 0);
            bus.redirect_x = ($urandom_range(0, 7) == 0);
            bus.halt_d     = ($urandom_range(0, 5) == 0);
            bus.halt_wb    = ($urandom_range(0, 3) == 0);
            bus.imemStall  = ($urandom_range(0, 4) == 0);
            bus.dmemStall  = ($urandom_range(0, 5) == 0);
            lu = bus.memRead_x && ((bus.useRs1_d && bus.rs1_d == bus.writeReg_x) ||
                                   (bus.useRs2_d && bus.rs2_d == bus.writeReg_x));
            inc = 1'b0; next_mode = mode; exp_ctl = C_FREEZE;
            if (mode == 0) begin
                if (bus.dmemStall)       begin exp_ctl = C_FREEZE; inc = 1'b1; end
                else if (bus.redirect_x) exp_ctl = C_REDIR;
                else if (lu)             begin exp_ctl = C_LDUSE;  inc = 1'b1; end
                else if (bus.imemStall)  begin exp_ctl = C_HOLDPC; inc = 1'b1; end
                else if (bus.halt_d)     begin exp_ctl = C_HOLDPC; next_mode = 1; end
                else                     exp_ctl = C_PASS;
            end else if (mode == 1) begin
                if (bus.dmemStall) begin
                    exp_ctl = C_FREEZE; inc = 1'b1;
                    if (bus.halt_wb) next_mode = 2;
                end else if (bus.redirect_x) begin
                    exp_ctl = C_REDIR; next_mode = 0;
                end else begin
                    exp_ctl = C_HOLDPC;
                    if (bus.halt_wb) next_mode = 2;
                end
            end
            #1;
            n_tests++; if (ctl() !== exp_ctl) begin n_fail++; $display("FAIL rand_ctl[%0d]: got %b exp %b", i, ctl(), exp_ctl); end
            n_tests++; if (bus.haltDone !== (mode == 2)) begin n_fail++; $display("FAIL rand_done[%0d]: got %b exp %b", i, bus.haltDone, mode == 2); end
            n_tests++; if (bus.stallCount !== 4'(cnt)) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d exp %0d", i, bus.stallCount, cnt); end
            if (inc && cnt < 15) cnt = cnt + 1;
            if (mode == 2) halted_cycles++;
            mode = next_mode;
        end
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_redirect_priority();
        test_dmem_redirect();
        test_halt();
        test_halt_variants();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
